// File: rtl/int_mem_pkg.sv
// Shared types and defaults for the input-map/kernel memory loader.
package int_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  localparam int IO_DATA_WIDTH_DEF = 16;
  localparam int REGION_BIT        = IO_DATA_WIDTH_DEF - 1;
  localparam int INPUT_WORDS_DEF   = 1 << 15;
  localparam int KERNEL_WORDS_DEF  = 1 << 9;

  // Offset must fall inside the addressed region.
  function automatic logic addr_in_range(input logic        kernel,
                                         input int unsigned offset,
                                         input int unsigned in_words,
                                         input int unsigned k_words);
    return kernel ? (offset < k_words) : (offset < in_words);
  endfunction

endpackage

// File: rtl/int_mem_loader_hold.sv
// Single-entry hold register for one side of the address/data pairing.
module stream_hold_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         held_o,
  output logic [W-1:0] data_o
);

  logic         held_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst_in || flush_i) begin
      held_q <= 1'b0;
    end else if (pop_i) begin
      held_q <= 1'b0;
    end else if (push_i) begin
      held_q <= 1'b1;
    end
  end

  // NOTE: payload needs no reset; it is only observed while held_q is set.
  always_ff @(posedge clk) begin
    if (push_i && !held_q) data_q <= data_i;
  end

  assign ready_o = !held_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

endmodule

// File: rtl/int_mem_loader.sv
// Pairs host address/data streams into write strobes for the input-map and
// kernel memories. Optional LOADER_CHECKSUM_EN adds a running sum of written data.
module int_mem_loader
  import int_mem_pkg::*;
#(
  parameter int IO_DATA_WIDTH = IO_DATA_WIDTH_DEF,
  parameter int INPUT_WORDS   = INPUT_WORDS_DEF,
  parameter int KERNEL_WORDS  = KERNEL_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     load_start,
  input  logic [IO_DATA_WIDTH-1:0] a_input,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [IO_DATA_WIDTH-1:0] b_input,
  input  logic                     b_valid,
  output logic                     b_ready,
  output logic [IO_DATA_WIDTH-1:0] mem_addr,
  output logic [IO_DATA_WIDTH-1:0] mem_din,
  output logic                     int_mem_we,
  output logic                     data_ready,
  output logic                     loading,
  output logic                     addr_err
`ifdef LOADER_CHECKSUM_EN
  ,output logic [31:0]             checksum
`endif
);

  localparam int RBIT = IO_DATA_WIDTH - 1;
  localparam int IN_CW = $clog2(INPUT_WORDS + 1);
  localparam int K_CW  = $clog2(KERNEL_WORDS + 1);

  loader_state_t           state_q;
  logic                    loading_q, data_ready_q, addr_err_q, we_q;
  logic [IO_DATA_WIDTH-1:0] mem_addr_q, mem_din_q;
  logic [IN_CW-1:0]        in_cnt_q;
  logic [K_CW-1:0]         k_cnt_q;

  logic a_free, b_free, a_held, b_held;
  logic [IO_DATA_WIDTH-1:0] a_hold, b_hold;
  logic enter_load, complete, issue, pair_ok;

  assign enter_load = !loading_q && load_start;
  assign complete   = (in_cnt_q == IN_CW'(INPUT_WORDS)) && (k_cnt_q == K_CW'(KERNEL_WORDS));
  assign issue      = loading_q && !complete && a_held && b_held;
  assign pair_ok    = addr_in_range(a_hold[RBIT], 32'(a_hold[RBIT-1:0]),
                                    INPUT_WORDS, KERNEL_WORDS);

  assign a_ready = loading_q && a_free;
  assign b_ready = loading_q && b_free;

  stream_hold_reg #(.W(IO_DATA_WIDTH)) u_a_hold (
    .clk     (clk),
    .rst_in  (rst_in),
    .flush_i (enter_load),
    .push_i  (a_valid && a_ready),
    .pop_i   (issue),
    .data_i  (a_input),
    .ready_o (a_free),
    .held_o  (a_held),
    .data_o  (a_hold)
  );

  stream_hold_reg #(.W(IO_DATA_WIDTH)) u_b_hold (
    .clk     (clk),
    .rst_in  (rst_in),
    .flush_i (enter_load),
    .push_i  (b_valid && b_ready),
    .pop_i   (issue),
    .data_i  (b_input),
    .ready_o (b_free),
    .held_o  (b_held),
    .data_o  (b_hold)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= IDLE;
      loading_q    <= 1'b0;
      data_ready_q <= 1'b0;
      addr_err_q   <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      in_cnt_q     <= '0;
      k_cnt_q      <= '0;
    end else begin
      // NOTE: strobe defaults low each cycle so it can only ever be one cycle wide.
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (load_start) begin
            state_q      <= LOAD;
            loading_q    <= 1'b1;
            data_ready_q <= 1'b0;
            addr_err_q   <= 1'b0;
            in_cnt_q     <= '0;
            k_cnt_q      <= '0;
          end
        end
        LOAD: begin
          if (complete) begin
            state_q      <= DONE;
            loading_q    <= 1'b0;
            data_ready_q <= 1'b1;
          end else if (issue) begin
            if (pair_ok) begin
              we_q       <= 1'b1;
              mem_addr_q <= a_hold;
              mem_din_q  <= b_hold;
              // Counts saturate; surplus in-range writes still go to memory.
              if (a_hold[RBIT]) begin
                if (k_cnt_q != K_CW'(KERNEL_WORDS)) k_cnt_q <= k_cnt_q + K_CW'(1);
              end else begin
                if (in_cnt_q != IN_CW'(INPUT_WORDS)) in_cnt_q <= in_cnt_q + IN_CW'(1);
              end
            end else begin
              addr_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          loading_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign int_mem_we = we_q;
  assign data_ready = data_ready_q;
  assign loading    = loading_q;
  assign addr_err   = addr_err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst_in || enter_load) begin
      checksum_q <= '0;
    end else if (we_q) begin
      checksum_q <= checksum_q + 32'(mem_din_q);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_int_mem_loader.sv
// Scoreboard bench for int_mem_loader with small region sizes (4 input, 2 kernel).
module tb_int_mem_loader;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int KW = 2;

  logic         clk = 1'b0;
  logic         rst_in = 1'b1;
  logic         load_start = 1'b0;
  logic [W-1:0] a_input = '0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [W-1:0] b_input = '0;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [W-1:0] mem_addr, mem_din;
  logic         int_mem_we, data_ready, loading, addr_err;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]  checksum;
`endif

  int_mem_loader #(.IO_DATA_WIDTH(W), .INPUT_WORDS(IW), .KERNEL_WORDS(KW)) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .load_start (load_start),
    .a_input    (a_input),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_input    (b_input),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .int_mem_we (int_mem_we),
    .data_ready (data_ready),
    .loading    (loading),
    .addr_err   (addr_err)
`ifdef LOADER_CHECKSUM_EN
    ,.checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  we_cnt = 0;
  int  last_we_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (int_mem_we === 1'b1) begin
      wr_t e;
      we_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_we", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", {16'h0, mem_addr}, {16'h0, e.addr});
        check("mem_din", {16'h0, mem_din}, {16'h0, e.data});
      end
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_a(input logic [W-1:0] v);
    int n = 0;
    a_input = v;
    a_valid = 1'b1;
    while (a_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("a_timeout", 32'd0, 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [W-1:0] v);
    int n = 0;
    b_input = v;
    b_valid = 1'b1;
    while (b_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] addr, input logic [W-1:0] data, input bit ok);
    wr_t e;
    e.addr = addr;
    e.data = data;
    if (ok) exp_q.push_back(e);
    fork
      send_a(addr);
      send_b(data);
    join
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (data_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, data_ready}, 32'd1);
    check({tag, "_done_lat"}, 32'(cyc - last_we_cyc), 32'd1);
    check({tag, "_loading"}, {31'd0, loading}, 32'd0);
    check({tag, "_a_ready"}, {31'd0, a_ready}, 32'd0);
    check({tag, "_b_ready"}, {31'd0, b_ready}, 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs;
    repeat (2) @(negedge clk);
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("rst_mem_din", {16'h0, mem_din}, 32'd0);
    check("rst_we", {31'd0, int_mem_we}, 32'd0);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_loading", {31'd0, loading}, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    rst_in = 1'b0;
    @(negedge clk);

    // Load 1: four input words, one out-of-range kernel word, two kernel words.
    we_cnt = 0;
    start_load();
    check("l1_loading", {31'd0, loading}, 32'd1);
    for (int i = 0; i < 4; i++) send_pair(16'(i), 16'(16'h0011 + i), 1'b1);
    send_pair(16'h8005, 16'h00EE, 1'b0);
    send_pair(16'h8000, 16'h0015, 1'b1);
    repeat (4) @(negedge clk);
    check("l1_addr_err", {31'd0, addr_err}, 32'd1);
    check("l1_not_done_early", {31'd0, data_ready}, 32'd0);
    check("l1_still_loading", {31'd0, loading}, 32'd1);
    check("l1_we_before_last", 32'(we_cnt), 32'd5);
    send_pair(16'h8001, 16'h0016, 1'b1);
    wait_done("l1");
    check("l1_strobes", 32'(we_cnt), 32'd6);
    check("l1_err_sticky", {31'd0, addr_err}, 32'd1);

    // Load 2: reload from DONE, then a skewed first pair.
    we_cnt = 0;
    start_load();
    check("reload_data_ready", {31'd0, data_ready}, 32'd0);
    check("reload_addr_err", {31'd0, addr_err}, 32'd0);
    check("reload_a_ready", {31'd0, a_ready}, 32'd1);
    check("reload_b_ready", {31'd0, b_ready}, 32'd1);
    a_input = 16'h0000;
    a_valid = 1'b1;
    @(negedge clk);
    check("skew_a_ready_drop", {31'd0, a_ready}, 32'd0);
    a_input = 16'h0001;
    repeat (4) @(negedge clk);
    check("skew_a_still_held", {31'd0, a_ready}, 32'd0);
    check("skew_no_we", 32'(we_cnt), 32'd0);
    exp_q.push_back({16'h0000, 16'h0021});
    b_input = 16'h0021;
    b_valid = 1'b1;
    hs = cyc;
    check("skew_b_ready", {31'd0, b_ready}, 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    a_valid = 1'b0;
    check("skew_we_not_yet", {31'd0, int_mem_we}, 32'd0);
    @(negedge clk);
    check("skew_we_lat2", {31'd0, int_mem_we}, 32'd1);
    check("skew_cycle", 32'(cyc - hs), 32'd2);
    for (int i = 1; i < 4; i++) send_pair(16'(i), 16'(16'h0021 + i), 1'b1);
    send_pair(16'h8000, 16'h0025, 1'b1);
    send_pair(16'h8001, 16'h0026, 1'b1);
    wait_done("l2");
    check("l2_strobes", 32'(we_cnt), 32'd6);

    // Load 3: reset after three pairs with an a word held and a b word in flight.
    we_cnt = 0;
    start_load();
    for (int i = 0; i < 3; i++) send_pair(16'(i), 16'(16'h0031 + i), 1'b1);
    send_a(16'h0003);
    repeat (3) @(negedge clk);
    check("mid_strobes", 32'(we_cnt), 32'd3);
    b_input = 16'h0034;
    b_valid = 1'b1;
    rst_in  = 1'b1;
    @(negedge clk);
    check("mrst_loading", {31'd0, loading}, 32'd0);
    check("mrst_a_ready", {31'd0, a_ready}, 32'd0);
    check("mrst_b_ready", {31'd0, b_ready}, 32'd0);
    check("mrst_we", {31'd0, int_mem_we}, 32'd0);
    check("mrst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("mrst_mem_din", {16'h0, mem_din}, 32'd0);
    check("mrst_data_ready", {31'd0, data_ready}, 32'd0);
    b_valid = 1'b0;
    rst_in  = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst_no_strobe", 32'(we_cnt), 32'd3);
    check("mrst_idle_ready", {31'd0, b_ready}, 32'd0);

    // Load 4: after reset, all six pairs are needed again.
    we_cnt = 0;
    start_load();
    for (int i = 0; i < 4; i++) send_pair(16'(i), 16'(16'h0041 + i), 1'b1);
    send_pair(16'h8000, 16'h0045, 1'b1);
    repeat (3) @(negedge clk);
    check("l4_not_done_early", {31'd0, data_ready}, 32'd0);
    send_pair(16'h8001, 16'h0046, 1'b1);
    wait_done("l4");
    check("l4_strobes", 32'(we_cnt), 32'd6);

`ifdef LOADER_CHECKSUM_EN
    start_load();
    check("cks_clear", checksum, 32'd0);
    send_pair(16'h0000, 16'hFFFF, 1'b1);
    send_pair(16'h0001, 16'hFFFF, 1'b1);
    send_pair(16'h0002, 16'h0002, 1'b1);
    repeat (3) @(negedge clk);
    check("checksum", checksum, 32'h0002_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
